// File: rtl/stream_deserializer_pkg.sv
// Shared definitions for the stream deserializer and other blocks on the
// valid/back-pressure stream interface.
package stream_deserializer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } deser_state_t;

    // Width needed to hold a count from 0 up to and including ratio.
    function automatic int count_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/stream_out_register.sv
// Output slice of a stream block: one-word holding register, out_valid and
// the back-pressure it returns upstream.
module stream_out_register
    import stream_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic [COUNT_WIDTH-1:0] load_count,
    input  logic                   load_last,
    input  logic                   out_back_pressure,
    output logic                   stall,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_last,
    output logic                   out_valid
);

    deser_state_t state;
    deser_state_t state_next;
    logic         transfer;

    assign out_valid = (state == HOLD);
    assign transfer  = out_valid & ~out_back_pressure;
    assign stall     = out_valid & out_back_pressure;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (load) state_next = HOLD;
            HOLD:    if (transfer && !load) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // A load while HOLD is only possible in a draining cycle, so the new word
    // replaces the departing one with no bubble.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_count <= load_count;
            out_last  <= load_last;
        end
    end

endmodule

// File: rtl/stream_deserializer.sv
// Packs RATIO narrow stream items into one wide word; in_last closes a word
// early and the lane count travels with it on out_count.
module stream_deserializer
    import stream_deserializer_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int RATIO       = 4,
    localparam int COUNT_WIDTH = count_width(RATIO)
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_back_pressure,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]      out_count,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_back_pressure
);

    localparam int                   IDX_WIDTH = $clog2(RATIO);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(RATIO - 1);

    logic [RATIO-1:0][DATA_WIDTH-1:0] acc;
    logic [RATIO-1:0][DATA_WIDTH-1:0] word;
    logic [IDX_WIDTH-1:0]             idx;
    logic [COUNT_WIDTH-1:0]           word_count;
    logic                             accept;
    logic                             complete;

    assign accept     = in_valid & ~in_back_pressure;
    assign complete   = accept & ((idx == LAST_IDX) | in_last);
    assign word_count = COUNT_WIDTH'(idx) + COUNT_WIDTH'(1);

    // Outgoing word: collected lanes below idx, the new item at idx, zeros above.
    always_comb begin
        for (int k = 0; k < RATIO; k++) begin
            if (IDX_WIDTH'(k) < idx) begin
                word[k] = acc[k];
            end else if (IDX_WIDTH'(k) == idx) begin
                word[k] = in_data;
            end else begin
                word[k] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            if (complete) begin
                acc <= '0;
                idx <= '0;
            end else begin
                acc[idx] <= in_data;
                idx      <= idx + IDX_WIDTH'(1);
            end
        end
    end

    stream_out_register #(
        .DATA_WIDTH  (DATA_WIDTH * RATIO),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_out_register (
        .clock             (clock),
        .resetN            (resetN),
        .load              (complete),
        .load_data         (word),
        .load_count        (word_count),
        .load_last         (in_last),
        .out_back_pressure (out_back_pressure),
        .stall             (in_back_pressure),
        .out_data          (out_data),
        .out_count         (out_count),
        .out_last          (out_last),
        .out_valid         (out_valid)
    );

endmodule

// File: tb/tb_stream_deserializer.sv
// Bench for stream_deserializer: directed packets with literal expectations,
// plus a queue-based packing model compared against the outputs every cycle.
module tb_stream_deserializer;

    localparam int DW    = 8;
    localparam int RATIO = 4;
    localparam int LIMIT = 200;

    logic            clock;
    logic            resetN;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_back_pressure;
    logic [31:0]     out_data;
    logic [2:0]      out_count;
    logic            out_last;
    logic            out_valid;
    logic            out_back_pressure;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        int          count;
        logic        last;
    } word_t;

    logic [DW-1:0] part[$];
    word_t         exp_q[$];
    word_t         w;
    logic          m_held;
    logic          m_accept;

    stream_deserializer #(
        .DATA_WIDTH (DW),
        .RATIO      (RATIO)
    ) dut (
        .clock             (clock),
        .resetN            (resetN),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_back_pressure  (in_back_pressure),
        .out_data          (out_data),
        .out_count         (out_count),
        .out_last          (out_last),
        .out_valid         (out_valid),
        .out_back_pressure (out_back_pressure)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: items gather in a list; a list of RATIO items or one ended by
    // in_last becomes an expected word, little-endian by arrival order.
    always @(negedge clock) begin
        if (!resetN) begin
            part.delete();
            exp_q.delete();
            check("reset_out_valid", 64'(out_valid), 64'(0));
            check("reset_out_data", 64'(out_data), 64'(0));
        end else begin
            m_held   = (exp_q.size() != 0);
            m_accept = in_valid && !(m_held && out_back_pressure);
            check("in_back_pressure", 64'(in_back_pressure), 64'(m_held && out_back_pressure));
            check("out_valid", 64'(out_valid), 64'(m_held));
            if (m_held && out_valid) begin
                check("out_data", 64'(out_data), 64'(exp_q[0].data));
                check("out_count", 64'(out_count), 64'(exp_q[0].count));
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
                if (!out_back_pressure) void'(exp_q.pop_front());
            end
            if (m_accept) begin
                part.push_back(in_data);
                if (part.size() == RATIO || in_last) begin
                    w.data = '0;
                    foreach (part[i]) w.data[i*DW +: DW] = part[i];
                    w.count = part.size();
                    w.last  = in_last;
                    exp_q.push_back(w);
                    part.delete();
                end
            end
        end
    end

    // Present one item and return just after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clock);
        while (in_back_pressure && waited < LIMIT) begin
            @(negedge clock);
            waited++;
        end
        check("send_wait_bound", 64'(waited < LIMIT), 64'(1));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [31:0] d,
                               input int c, input logic l);
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_data"}, 64'(out_data), 64'(d));
        check({name, "_count"}, 64'(out_count), 64'(c));
        check({name, "_last"}, 64'(out_last), 64'(l));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN            = 1'b0;
        in_data           = '0;
        in_valid          = 1'b0;
        in_last           = 1'b0;
        out_back_pressure = 1'b0;
        repeat (3) tick();
        check("rst_count", 64'(out_count), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_bp", 64'(in_back_pressure), 64'(0));
        resetN = 1'b1;
        tick();

        // Full word, one cycle of out_valid.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        expect_word("full", 32'h44332211, 4, 1'b0);
        tick();
        check("full_one_cycle", 64'(out_valid), 64'(0));

        // Early close with two lanes.
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        expect_word("partial", 32'h0000A2A1, 2, 1'b1);

        // Stall for 5 cycles with an item waiting.
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b0);
        out_back_pressure = 1'b1;
        in_valid          = 1'b1;
        in_data           = 8'hC1;
        repeat (5) begin
            @(negedge clock);
            check("stall_bp", 64'(in_back_pressure), 64'(1));
            check("stall_data", 64'(out_data), 64'(32'hB4B3B2B1));
            tick();
        end
        out_back_pressure = 1'b0;
        @(negedge clock);
        check("release_bp", 64'(in_back_pressure), 64'(0));
        tick();
        in_valid = 1'b0;
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        expect_word("after_stall", 32'hC4C3C2C1, 4, 1'b0);

        // Back-to-back words.
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0);
            if (i == 4) expect_word("b2b_first", 32'h04030201, 4, 1'b0);
        end
        expect_word("b2b_second", 32'h08070605, 4, 1'b0);

        // Single-lane words back-to-back: reload while draining, no bubble.
        send(8'hD1, 1'b1);
        expect_word("single_a", 32'h000000D1, 1, 1'b1);
        send(8'hD2, 1'b1);
        expect_word("single_b", 32'h000000D2, 1, 1'b1);

        // Close at the last lane, then a partial word kept across idle cycles.
        send(8'hF1, 1'b0);
        send(8'hF2, 1'b0);
        send(8'hF3, 1'b0);
        send(8'hF4, 1'b1);
        expect_word("full_last", 32'hF4F3F2F1, 4, 1'b1);
        send(8'hE1, 1'b0);
        repeat (10) tick();
        send(8'hE2, 1'b1);
        expect_word("idle_kept", 32'h0000E2E1, 2, 1'b1);

        // Reset mid-word discards the partial word.
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        resetN = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'(0));
        repeat (2) tick();
        resetN = 1'b1;
        tick();
        send(8'h77, 1'b1);
        expect_word("after_reset", 32'h00000077, 1, 1'b1);

        // Random traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            in_valid          = ($urandom_range(0, 3) != 0);
            in_data           = 8'($urandom);
            in_last           = ($urandom_range(0, 5) == 0);
            out_back_pressure = ($urandom_range(0, 2) == 0);
            tick();
        end
        in_valid          = 1'b0;
        in_last           = 1'b0;
        out_back_pressure = 1'b0;
        repeat (3) tick();
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
